// File: rtl/spi_pkg.sv
// Shared types and helpers for the configurable SPI master.
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LEAD  = 2'd1,
        XFER  = 2'd2,
        TRAIL = 2'd3
    } state_t;

    localparam logic [1:0] MODE0 = 2'b00;
    localparam logic [1:0] MODE1 = 2'b01;
    localparam logic [1:0] MODE2 = 2'b10;
    localparam logic [1:0] MODE3 = 2'b11;

    function automatic logic [63:0] bitrev(input logic [63:0] v);
        logic [63:0] r;
        for (int i = 0; i < 64; i++) begin
            r[i] = v[63-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/spi_clkgen.sv
// Half-period timer: counts down a latched divider and emits a
// one-cycle tick every div+1 enabled cycles.
module spi_clkgen #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             i_load,
    input  logic [DIV_W-1:0] i_div,
    input  logic             i_en,
    output logic             o_tick
);

    logic [DIV_W-1:0] r_div;
    logic [DIV_W-1:0] r_cnt;
    logic             w_zero;

    assign w_zero = (r_cnt == '0);
    assign o_tick = i_en & w_zero;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_div <= '0;
            r_cnt <= '0;
        end else if (i_load) begin
            r_div <= i_div;
            r_cnt <= i_div;
        end else if (i_en) begin
            r_cnt <= w_zero ? r_div : r_cnt - 1'b1;
        end
    end

endmodule

// File: rtl/spi_master_cfg.sv
// Runtime-configurable SPI master with start/busy/done handshake.
// Mode, divider, bit order and chip select are latched at accept.
module spi_master_cfg
    import spi_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CS_NUM = 4,
    parameter int DIV_W  = 16,
    localparam int CSW   = (CS_NUM > 1) ? $clog2(CS_NUM) : 1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic              cpol,
    input  logic              cpha,
    input  logic              lsb_first,
    input  logic [DIV_W-1:0]  clk_div,
    input  logic [CSW-1:0]    cs_sel,
    input  logic [DATA_W-1:0] tx_data,
    output logic [DATA_W-1:0] rx_data,
    output logic              busy,
    output logic              done,
    output logic              sck,
    output logic [CS_NUM-1:0] csn,
    output logic              mosi,
    input  logic              miso
);

    localparam int EW = $clog2(2 * DATA_W) + 1;

    state_t            r_state, w_state_nxt;
    logic              r_sck, w_sck_nxt;
    logic              r_mosi, w_mosi_nxt;
    logic [CS_NUM-1:0] r_csn, w_csn_nxt;
    logic              r_busy, w_busy_nxt;
    logic              r_done, w_done_nxt;
    logic [DATA_W-1:0] r_rx_data, w_rx_data_nxt;
    logic [DATA_W-1:0] r_tx, w_tx_nxt;
    logic [DATA_W-1:0] r_rx, w_rx_nxt;
    logic [EW-1:0]     r_edge, w_edge_nxt;
    logic [1:0]        r_mode, w_mode_nxt;
    logic              r_lsb, w_lsb_nxt;

    logic              w_load;
    logic              w_en;
    logic              w_tick;
    logic              w_lead;
    logic              w_last;
    logic              w_sample;
    logic [CS_NUM-1:0] w_csn_sel;
    logic [DATA_W-1:0] w_tx_rev;
    logic [DATA_W-1:0] w_rx_rev;
    logic [DATA_W-1:0] w_tx_ord;

    assign w_en     = (r_state != IDLE);
    assign w_lead   = ~r_edge[0];
    assign w_last   = (r_edge == EW'(2 * DATA_W - 1));
    assign w_tx_rev = DATA_W'(bitrev(64'(tx_data)) >> (64 - DATA_W));
    assign w_rx_rev = DATA_W'(bitrev(64'(r_rx)) >> (64 - DATA_W));
    assign w_tx_ord = lsb_first ? w_tx_rev : tx_data;

    spi_clkgen #(
        .DIV_W (DIV_W)
    ) u_clkgen (
        .clk    (clk),
        .rstn   (rstn),
        .i_load (w_load),
        .i_div  (clk_div),
        .i_en   (w_en),
        .o_tick (w_tick)
    );

    // Out-of-range selects match no line, so every csn stays high.
    always_comb begin
        w_csn_sel = '1;
        for (int i = 0; i < CS_NUM; i++) begin
            if (cs_sel == CSW'(i)) begin
                w_csn_sel[i] = 1'b0;
            end
        end
    end

    always_comb begin
        unique case (r_mode)
            MODE0, MODE2: w_sample = w_lead;
            MODE1, MODE3: w_sample = ~w_lead;
            default:      w_sample = w_lead;
        endcase
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_sck_nxt     = r_sck;
        w_mosi_nxt    = r_mosi;
        w_csn_nxt     = r_csn;
        w_busy_nxt    = r_busy;
        w_done_nxt    = 1'b0;
        w_rx_data_nxt = r_rx_data;
        w_tx_nxt      = r_tx;
        w_rx_nxt      = r_rx;
        w_edge_nxt    = r_edge;
        w_mode_nxt    = r_mode;
        w_lsb_nxt     = r_lsb;
        w_load        = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_sck_nxt  = cpol;
                w_mosi_nxt = 1'b0;
                w_csn_nxt  = '1;
                w_busy_nxt = 1'b0;
                if (start) begin
                    w_load      = 1'b1;
                    w_state_nxt = LEAD;
                    w_busy_nxt  = 1'b1;
                    w_csn_nxt   = w_csn_sel;
                    w_mode_nxt  = {cpol, cpha};
                    w_lsb_nxt   = lsb_first;
                    w_edge_nxt  = '0;
                    w_rx_nxt    = '0;
                    // Mode 0/2 must present the first bit before the first edge.
                    if (!cpha) begin
                        w_mosi_nxt = w_tx_ord[DATA_W-1];
                        w_tx_nxt   = w_tx_ord << 1;
                    end else begin
                        w_tx_nxt   = w_tx_ord;
                    end
                end
            end
            LEAD: begin
                if (w_tick) begin
                    w_state_nxt = XFER;
                end
            end
            XFER: begin
                if (w_tick) begin
                    w_sck_nxt  = ~r_sck;
                    w_edge_nxt = r_edge + 1'b1;
                    if (w_sample) begin
                        w_rx_nxt = {r_rx[DATA_W-2:0], miso};
                    end else if (!w_last) begin
                        w_mosi_nxt = r_tx[DATA_W-1];
                        w_tx_nxt   = r_tx << 1;
                    end
                    if (w_last) begin
                        w_state_nxt = TRAIL;
                    end
                end
            end
            TRAIL: begin
                if (w_tick) begin
                    w_state_nxt   = IDLE;
                    w_csn_nxt     = '1;
                    w_rx_data_nxt = r_lsb ? w_rx_rev : r_rx;
                    w_done_nxt    = 1'b1;
                    w_busy_nxt    = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state   <= IDLE;
            r_sck     <= 1'b0;
            r_mosi    <= 1'b0;
            r_csn     <= '1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_rx_data <= '0;
            r_tx      <= '0;
            r_rx      <= '0;
            r_edge    <= '0;
            r_mode    <= MODE0;
            r_lsb     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_sck     <= w_sck_nxt;
            r_mosi    <= w_mosi_nxt;
            r_csn     <= w_csn_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
            r_rx_data <= w_rx_data_nxt;
            r_tx      <= w_tx_nxt;
            r_rx      <= w_rx_nxt;
            r_edge    <= w_edge_nxt;
            r_mode    <= w_mode_nxt;
            r_lsb     <= w_lsb_nxt;
        end
    end

    assign rx_data = r_rx_data;
    assign busy    = r_busy;
    assign done    = r_done;
    assign sck     = r_sck;
    assign csn     = r_csn;
    assign mosi    = r_mosi;

endmodule

// File: tb/tb_spi_master_cfg.sv
// Scoreboard bench for spi_master_cfg: an 8-bit instance with a mode-aware
// slave model and a 32-bit instance in mosi->miso loopback.
module tb_spi_master_cfg;

    typedef struct {
        logic [7:0] rx;
        logic [7:0] wr;
        logic [2:0] csn;
        int         lat;
        logic       cpol;
        bit         chk_wire;
    } exp_t;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    // 8-bit instance
    logic        start8 = 1'b0;
    logic        cpol8 = 1'b0;
    logic        cpha8 = 1'b0;
    logic        lsb8 = 1'b0;
    logic [15:0] div8 = '0;
    logic [1:0]  cs8 = '0;
    logic [7:0]  tx8 = '0;
    logic [7:0]  rx8;
    logic        busy8, done8, sck8, mosi8;
    logic [2:0]  csn8;
    logic        miso8 = 1'b0;

    // 32-bit instance
    logic        start32 = 1'b0;
    logic        cpol32 = 1'b0;
    logic        cpha32 = 1'b0;
    logic        lsb32 = 1'b0;
    logic [15:0] div32 = '0;
    logic [1:0]  cs32 = '0;
    logic [31:0] tx32 = '0;
    logic [31:0] rx32;
    logic        busy32, done32, sck32, mosi32;
    logic [3:0]  csn32;
    logic        miso32;

    assign miso32 = mosi32;

    spi_master_cfg #(.DATA_W(8), .CS_NUM(3), .DIV_W(16)) u_dut8 (
        .clk(clk), .rstn(rstn), .start(start8), .cpol(cpol8), .cpha(cpha8),
        .lsb_first(lsb8), .clk_div(div8), .cs_sel(cs8), .tx_data(tx8),
        .rx_data(rx8), .busy(busy8), .done(done8), .sck(sck8), .csn(csn8),
        .mosi(mosi8), .miso(miso8)
    );

    spi_master_cfg #(.DATA_W(32), .CS_NUM(4), .DIV_W(16)) u_dut32 (
        .clk(clk), .rstn(rstn), .start(start32), .cpol(cpol32), .cpha(cpha32),
        .lsb_first(lsb32), .clk_div(div32), .cs_sel(cs32), .tx_data(tx32),
        .rx_data(rx32), .busy(busy32), .done(done32), .sck(sck32), .csn(csn32),
        .mosi(mosi32), .miso(miso32)
    );

    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    exp_t exp_q[$];
    int   n_push = 0;
    int   n_done8 = 0;
    int   n_done32 = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] rev8(input logic [7:0] v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = v[7-i];
        return r;
    endfunction

    always @(posedge clk) cyc++;

    // Slave model: reacts at negedge to sck toggles seen since the last one.
    logic       s_cpol = 1'b0;
    logic       s_cpha = 1'b0;
    logic [7:0] s_word = '0;
    logic [7:0] s_rx = '0;
    bit         s_act = 1'b0;
    logic       s_sck_prev = 1'b0;
    int         s_idx = 0;

    always @(negedge clk) begin
        if (csn8 == 3'b111) begin
            s_act = 1'b0;
            miso8 = 1'b0;
        end else if (!s_act) begin
            s_act = 1'b1;
            s_rx  = '0;
            s_idx = 7;
            if (!s_cpha) begin
                miso8 = s_word[7];
                s_idx = 6;
            end
        end
        if (s_act && sck8 != s_sck_prev) begin
            if ((sck8 != s_cpol) ^ s_cpha) begin
                s_rx = {s_rx[6:0], mosi8};
            end else if (s_idx >= 0) begin
                miso8 = s_word[s_idx];
                s_idx--;
            end
        end
        s_sck_prev = sck8;
    end

    // Scoreboard side for the 8-bit instance.
    bit         pbusy8 = 1'b0;
    int         t8 = 0;
    logic [2:0] csn_snap8 = '0;

    always @(negedge clk) begin
        exp_t e;
        if (busy8 && !pbusy8) begin
            t8 = cyc;
            csn_snap8 = csn8;
        end
        if (done8) begin
            n_done8++;
            chk("q_depth", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("rx8", rx8, e.rx);
                chk("lat8", cyc - t8, e.lat);
                chk("csn_xfer", csn_snap8, e.csn);
                chk("csn_done", csn8, 3'b111);
                chk("sck_end", sck8, e.cpol);
                chk("busy_done", busy8, 1'b0);
                if (e.chk_wire) chk("mosi_wire", s_rx, e.wr);
            end
        end
        pbusy8 = busy8;
    end

    // Checker for the 32-bit loopback instance.
    bit          pbusy32 = 1'b0;
    logic        psck32 = 1'b0;
    logic        pmosi32 = 1'b0;
    int          t32 = 0;
    int          rises32 = 0;
    int          bad32 = 0;
    logic [3:0]  csn_snap32 = '0;
    logic [31:0] e32_rx = '0;
    int          e32_lat = 0;

    always @(negedge clk) begin
        if (busy32 && !pbusy32) begin
            t32 = cyc;
            csn_snap32 = csn32;
            rises32 = 0;
            bad32 = 0;
        end
        if (busy32 && sck32 && !psck32) begin
            rises32++;
            if (mosi32 !== pmosi32) bad32++;
        end
        if (done32) begin
            n_done32++;
            chk("rx32", rx32, e32_rx);
            chk("lat32", cyc - t32, e32_lat);
            chk("csn32", csn_snap32, 4'b1110);
            chk("rises32", rises32, 32);
            chk("mosi_stable32", bad32, 0);
        end
        pbusy32 = busy32;
        psck32 = sck32;
        pmosi32 = mosi32;
    end

    task automatic push8(input logic [1:0] mode, input logic lsb, input logic [15:0] div,
                         input logic [1:0] cs, input logic [7:0] tx, input logic [7:0] sw);
        exp_t e;
        e.csn = 3'b111;
        if (cs < 2'd3) e.csn[cs] = 1'b0;
        e.chk_wire = (cs < 2'd3);
        e.rx = e.chk_wire ? (lsb ? rev8(sw) : sw) : 8'h00;
        e.wr = lsb ? rev8(tx) : tx;
        e.lat = 18 * (int'(div) + 1);
        e.cpol = mode[1];
        exp_q.push_back(e);
        n_push++;
    endtask

    task automatic run8(input logic [1:0] mode, input logic lsb, input logic [15:0] div,
                        input logic [1:0] cs, input logic [7:0] tx, input logic [7:0] sw,
                        input bit scr);
        int n0;
        int k;
        @(negedge clk);
        cpol8 = mode[1]; cpha8 = mode[0]; lsb8 = lsb;
        div8 = div; cs8 = cs; tx8 = tx;
        s_cpol = mode[1]; s_cpha = mode[0]; s_word = sw;
        repeat (2) @(negedge clk);
        chk("sck_idle", sck8, mode[1]);
        push8(mode, lsb, div, cs, tx, sw);
        n0 = n_done8;
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        if (scr) begin
            repeat (6) @(negedge clk);
            cpol8 = ~cpol8; cpha8 = ~cpha8; lsb8 = ~lsb8;
            div8 = 16'd7; cs8 = cs + 2'd1; tx8 = ~tx;
            start8 = 1'b1;
            @(negedge clk);
            start8 = 1'b0;
        end
        k = 0;
        while (n_done8 == n0 && k < 2000) begin
            @(posedge clk);
            k++;
        end
        chk("done8_seen", n_done8 - n0, 1);
    endtask

    task automatic b2b();
        logic [7:0] txs [3];
        logic [7:0] sws [3];
        logic [1:0] css [3];
        int k;
        txs[0] = 8'h11; txs[1] = 8'h22; txs[2] = 8'h33;
        sws[0] = 8'hA1; sws[1] = 8'hB2; sws[2] = 8'hC3;
        css[0] = 2'd1;  css[1] = 2'd2;  css[2] = 2'd1;
        @(negedge clk);
        cpol8 = 1'b0; cpha8 = 1'b1; lsb8 = 1'b0; div8 = 16'd2;
        s_cpol = 1'b0; s_cpha = 1'b1;
        repeat (2) @(negedge clk);
        cs8 = css[0]; tx8 = txs[0]; s_word = sws[0];
        push8(2'b01, 1'b0, 16'd2, css[0], txs[0], sws[0]);
        start8 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            k = 0;
            @(negedge clk);
            while (!done8 && k < 500) begin
                @(negedge clk);
                k++;
            end
            chk("b2b_done", done8, 1'b1);
            if (i < 2) begin
                cs8 = css[i+1]; tx8 = txs[i+1]; s_word = sws[i+1];
                push8(2'b01, 1'b0, 16'd2, css[i+1], txs[i+1], sws[i+1]);
            end else begin
                start8 = 1'b0;
            end
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic rst_mid();
        int n0;
        @(negedge clk);
        cpol8 = 1'b0; cpha8 = 1'b0; lsb8 = 1'b0; div8 = 16'd1;
        cs8 = 2'd0; tx8 = 8'hF0;
        s_cpol = 1'b0; s_cpha = 1'b0; s_word = 8'h0F;
        n0 = n_done8;
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (16) @(negedge clk);
        rstn = 1'b0;
        #1;
        chk("rst_sck", sck8, 1'b0);
        chk("rst_csn", csn8, 3'b111);
        chk("rst_mosi", mosi8, 1'b0);
        chk("rst_busy", busy8, 1'b0);
        chk("rst_rx", rx8, 8'h00);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        repeat (50) @(negedge clk);
        chk("rst_no_done", n_done8 - n0, 0);
    endtask

    initial begin
        int n0;
        int k;
        repeat (3) @(negedge clk);
        chk("init_sck", sck8, 1'b0);
        chk("init_csn", csn8, 3'b111);
        chk("init_mosi", mosi8, 1'b0);
        chk("init_busy", busy8, 1'b0);
        chk("init_done", done8, 1'b0);
        chk("init_rx", rx8, 8'h00);
        rstn = 1'b1;

        @(negedge clk);
        div32 = 16'd3; cs32 = 2'd0; tx32 = 32'hA5A5A5A5;
        e32_rx = 32'hA5A5A5A5;
        e32_lat = (2 * 32 + 2) * 4;
        n0 = n_done32;
        start32 = 1'b1;
        @(negedge clk);
        start32 = 1'b0;
        k = 0;
        while (n_done32 == n0 && k < 1000) begin
            @(posedge clk);
            k++;
        end
        chk("done32_seen", n_done32 - n0, 1);

        for (int m = 0; m < 4; m++) begin
            run8(2'(m), 1'b0, 16'd1, 2'd0, 8'hC3, 8'h3C, m == 2);
        end
        run8(2'b00, 1'b1, 16'd1, 2'd1, 8'h01, 8'h80, 1'b0);
        run8(2'b11, 1'b0, 16'd0, 2'd2, 8'h96, 8'h69, 1'b0);
        run8(2'b01, 1'b0, 16'd1, 2'd3, 8'h5A, 8'hFF, 1'b0);
        b2b();
        rst_mid();
        run8(2'b10, 1'b1, 16'd2, 2'd0, 8'hE1, 8'h2D, 1'b0);

        repeat (5) @(negedge clk);
        chk("q_empty", exp_q.size(), 0);
        chk("done_count", n_done8, n_push);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
